// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage with single-outstanding imem handshake
// Holds the PC, fetches one word at a time and parks a stalled word in a hold buffer.
module fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] PC_STEP  = 32'd4,
   parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   input  logic        imem_ready,
   output logic [31:0] pc_out,
   output logic [31:0] instruction,
   output logic        fetch_valid
);

   typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] hold_instr_q, hold_instr_d;
   logic [31:0] hold_pc_q, hold_pc_d;
   logic [31:0] pc_out_d, instr_d;
   logic        valid_d;

   assign imem_addr = pc_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= IDLE;
         pc_q         <= RESET_PC;
         hold_instr_q <= NOP_WORD;
         hold_pc_q    <= 32'h0;
         pc_out       <= 32'h0;
         instruction  <= NOP_WORD;
         fetch_valid  <= 1'b0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         hold_instr_q <= hold_instr_d;
         hold_pc_q    <= hold_pc_d;
         pc_out       <= pc_out_d;
         instruction  <= instr_d;
         fetch_valid  <= valid_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      hold_instr_d = hold_instr_q;
      hold_pc_d    = hold_pc_q;
      pc_out_d     = pc_out;
      instr_d      = instruction;
      valid_d      = fetch_valid;
      imem_req     = 1'b0;

      case (state_q)
         IDLE: begin
            state_d = FETCH;
         end
         FETCH: begin
            imem_req = 1'b1;
            if (imem_ready) begin
               pc_d = pc_q + PC_STEP;
               if (stall) begin
                  hold_instr_d = imem_rdata;
                  hold_pc_d    = pc_q;
                  state_d      = HOLD;
               end else begin
                  instr_d  = imem_rdata;
                  pc_out_d = pc_q;
                  valid_d  = 1'b1;
               end
            end else if (!stall) begin
               instr_d = NOP_WORD;
               valid_d = 1'b0;
            end
         end
         HOLD: begin
            if (!stall) begin
               instr_d  = hold_instr_q;
               pc_out_d = hold_pc_q;
               valid_d  = 1'b1;
               state_d  = FETCH;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Redirect wins over stall and discards any in-flight or parked word.
      if (branch_taken) begin
         pc_d    = {branch_target[31:2], 2'b00};
         instr_d = NOP_WORD;
         valid_d = 1'b0;
         state_d = FETCH;
      end
   end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage; produces the PC/instruction pair consumed by the IF/ID pipeline register.
- Holds the program counter and drives a single-outstanding-request handshake to instruction memory.
- Supports decode-side stall and branch redirect; delivered word format is op[31:30], func[29:28], I[27], V[26], RS1[25:22], RS2[21:18], RS3[17:14], imm[25:0].
- Registers outputs on posedge clk so they are stable before the IF/ID register samples on negedge.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
PC_STEP, 4, byte increment per fetched instruction
NOP_WORD, 32'h0000_0000, instruction value driven during bubbles

Ports:
clk  input  1  clock; all state updates on posedge
rst  input  1  asynchronous, active-low reset (0 = reset asserted)
stall  input  1  decode cannot accept; hold pc_out/instruction/fetch_valid
branch_taken  input  1  redirect request, one-cycle pulse
branch_target  input  32  redirect address
imem_req  output  1  fetch request to instruction memory
imem_addr  output  32  fetch byte address (= internal pc)
imem_rdata  input  32  fetched word, valid when imem_ready=1
imem_ready  input  1  memory response; may assert in the request cycle or later
pc_out  output  32  address of the delivered instruction
instruction  output  32  delivered instruction word
fetch_valid  output  1  pc_out/instruction hold a real instruction

Behaviour:
- Reset (rst=0, async):
  - pc=RESET_PC, state=IDLE, hold buffer empty.
  - pc_out=0, instruction=NOP_WORD, fetch_valid=0, imem_req=0.
- States: IDLE, FETCH, HOLD. imem_addr=pc at all times.
- IDLE:
  - imem_req=0.
  - Next posedge goes to FETCH; gives one quiet cycle after reset release.
- FETCH: imem_req=1.
  - imem_ready=1, stall=0: instruction<=imem_rdata, pc_out<=pc, fetch_valid<=1, pc<=pc+PC_STEP; stay in FETCH.
  - imem_ready=1, stall=1: hold_instr<=imem_rdata, hold_pc<=pc, pc<=pc+PC_STEP; outputs unchanged; go to HOLD.
  - imem_ready=0, stall=0: bubble (instruction<=NOP_WORD, fetch_valid<=0, pc_out unchanged).
  - imem_ready=0, stall=1: outputs unchanged.
- HOLD: imem_req=0.
  - stall=1: remain in HOLD; all outputs unchanged.
  - stall=0: instruction<=hold_instr, pc_out<=hold_pc, fetch_valid<=1; go to FETCH; next request issues the following cycle.
- Redirect (branch_taken=1):
  - Highest priority in every state; overrides stall.
  - pc<=branch_target with bits[1:0] forced to 00.
  - instruction<=NOP_WORD, fetch_valid<=0; hold buffer discarded; state<=FETCH.
  - imem_rdata/imem_ready in the same cycle are ignored.
- Latency:
  - Zero-wait memory: instruction appears on the posedge after the ready cycle; sustained 1 instruction/cycle.
  - First valid output is the 2nd posedge after reset release (IDLE, then FETCH).
- Arithmetic: pc+PC_STEP is modulo 2^32; 32'hFFFF_FFFC wraps to 0 with no flag.
- Stall is sampled only at posedge. An accepted word is never dropped or duplicated unless a redirect occurs.
- Reset asserted mid-request: state returns to IDLE immediately; a late imem_ready after reset release is ignored because imem_req=0 in IDLE.
- Never more than one outstanding request; imem_req deasserts in HOLD and IDLE.

Test Plan:
- Reset release, zero-wait memory returning addr+32'h100: pc_out/instruction = 0/100, 4/104, 8/108 on consecutive cycles; fetch_valid=1 from 2nd posedge.
- Memory with 2 wait cycles: fetch_valid=0 for 2 cycles between words; pc_out steps 0,4,8 with no skips.
- Stall asserted for 3 cycles during ready at pc=8: outputs hold pc 4; imem_req low in HOLD; after release, pc_out=8 then 12.
- branch_taken=1 with branch_target=32'h0000_0043 while stall=1: next cycle fetch_valid=0, imem_addr=32'h40; then pc_out=32'h40 is delivered.
- RESET_PC=32'hFFFF_FFF8, zero-wait memory: pc_out sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
- rst=0 pulsed mid-wait while memory asserts ready one cycle after release: outputs return to reset values; the late response is not delivered; fetch restarts at RESET_PC.
